// File: rtl/pipeline_pkg.sv
// Shared pipeline constants used by the fetch stage and its helpers.
package pipeline_pkg;

    localparam int          XLEN_DEF    = 64;
    localparam int          INSTR_W_DEF = 32;
    localparam int          PC_INC      = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: owns the PC, honours stall/flush, counts hazard cycles.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter int                XLEN     = XLEN_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCWrite,
    input  logic               IF_ID_Write,
    input  logic               Flush,
    input  logic [XLEN-1:0]    branch_target,
    output logic [XLEN-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [XLEN-1:0]    IF_ID_pc,
    output logic [INSTR_W-1:0] IF_ID_instr,
    output logic               IF_ID_valid,
    output logic               misaligned_target,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    logic [XLEN-1:0]    pc_q,        pc_d;
    logic [XLEN-1:0]    ifIdPc_q,    ifIdPc_d;
    logic [INSTR_W-1:0] ifIdInstr_q, ifIdInstr_d;
    logic               ifIdValid_q, ifIdValid_d;
    logic               misaligned_q, misaligned_d;
    logic               stallInc;

    // Flush overrides both write enables; otherwise PC and IF/ID update independently.
    always_comb begin
        pc_d         = pc_q;
        ifIdPc_d     = ifIdPc_q;
        ifIdInstr_d  = ifIdInstr_q;
        ifIdValid_d  = ifIdValid_q;
        misaligned_d = misaligned_q;
        if (Flush) begin
            pc_d         = {branch_target[XLEN-1:2], 2'b00};
            ifIdPc_d     = '0;
            ifIdInstr_d  = INSTR_W'(NOP_INSTR);
            ifIdValid_d  = 1'b0;
            misaligned_d = misaligned_q | (|branch_target[1:0]);
        end else begin
            if (PCWrite) begin
                pc_d = pc_q + XLEN'(PC_INC);
            end
            if (IF_ID_Write) begin
                ifIdPc_d    = pc_q;
                ifIdInstr_d = imem_rdata;
                ifIdValid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifIdPc_q     <= '0;
            ifIdInstr_q  <= INSTR_W'(NOP_INSTR);
            ifIdValid_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifIdPc_q     <= ifIdPc_d;
            ifIdInstr_q  <= ifIdInstr_d;
            ifIdValid_q  <= ifIdValid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign stallInc = !Flush && !PCWrite && !IF_ID_Write;

    sat_counter #(.CNT_W(CNT_W)) u_stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (stallInc),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (Flush),
        .count (flush_count)
    );

    assign imem_addr         = pc_q;
    assign IF_ID_pc          = ifIdPc_q;
    assign IF_ID_instr       = ifIdInstr_q;
    assign IF_ID_valid       = ifIdValid_q;
    assign misaligned_target = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0, second instance for wrap and saturation.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [63:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset = 1'b1, pcWrite = 1'b1, ifIdWrite = 1'b1, flush = 1'b0;
    logic [63:0] branchTarget = '0;
    logic [63:0] imemAddr, ifIdPc;
    logic [31:0] imemRdata, ifIdInstr;
    logic        ifIdValid, misaligned;
    logic [31:0] stallCount, flushCount;

    logic        reset2 = 1'b1, pcWrite2 = 1'b1, ifIdWrite2 = 1'b1, flush2 = 1'b0;
    logic [63:0] branchTarget2 = '0;
    logic [63:0] imemAddr2, ifIdPc2;
    logic [31:0] imemRdata2, ifIdInstr2;
    logic        ifIdValid2, misaligned2;
    logic [1:0]  stallCount2, flushCount2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // ROM contents: word i holds i+1
    assign imemRdata  = 32'(imemAddr >> 2) + 32'd1;
    assign imemRdata2 = 32'(imemAddr2 >> 2) + 32'd1;

    fetch_stage #(.XLEN(64), .INSTR_W(32), .RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .PCWrite(pcWrite), .IF_ID_Write(ifIdWrite), .Flush(flush),
        .branch_target(branchTarget), .imem_addr(imemAddr), .imem_rdata(imemRdata),
        .IF_ID_pc(ifIdPc), .IF_ID_instr(ifIdInstr), .IF_ID_valid(ifIdValid),
        .misaligned_target(misaligned), .stall_count(stallCount), .flush_count(flushCount)
    );

    fetch_stage #(.XLEN(64), .INSTR_W(32), .RESET_PC(TOP_PC), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset2), .PCWrite(pcWrite2), .IF_ID_Write(ifIdWrite2), .Flush(flush2),
        .branch_target(branchTarget2), .imem_addr(imemAddr2), .imem_rdata(imemRdata2),
        .IF_ID_pc(ifIdPc2), .IF_ID_instr(ifIdInstr2), .IF_ID_valid(ifIdValid2),
        .misaligned_target(misaligned2), .stall_count(stallCount2), .flush_count(flushCount2)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pcw, input logic ifw,
                                 input logic fl, input logic [63:0] tgt);
        reset        = rst;
        pcWrite      = pcw;
        ifIdWrite    = ifw;
        flush        = fl;
        branchTarget = tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pc"},    imemAddr,   64'h0);
        checkOutput({tag, "_ifpc"},  ifIdPc,     64'h0);
        checkOutput({tag, "_instr"}, ifIdInstr,  NOP);
        checkOutput({tag, "_valid"}, ifIdValid,  1'b0);
        checkOutput({tag, "_mis"},   misaligned, 1'b0);
        checkOutput({tag, "_stall"}, stallCount, 32'd0);
        checkOutput({tag, "_flush"}, flushCount, 32'd0);
    endtask

    initial begin
        applyStimulus(1, 1, 1, 0, 0);
        checkResetState("rst");

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 0, 0);
            checkOutput("run_ifpc",  ifIdPc,    64'(4 * i));
            checkOutput("run_instr", ifIdInstr, 32'(i + 1));
            checkOutput("run_valid", ifIdValid, 1'b1);
        end
        checkOutput("run_pc", imemAddr, 64'h10);

        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput("stall_pc",    imemAddr,   64'h10);
            checkOutput("stall_ifpc",  ifIdPc,     64'hC);
            checkOutput("stall_instr", ifIdInstr,  32'd4);
            checkOutput("stall_cnt",   stallCount, 32'(i));
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("release_pc",    imemAddr,  64'h14);
        checkOutput("release_ifpc",  ifIdPc,    64'h10);
        checkOutput("release_instr", ifIdInstr, 32'd5);

        repeat (3) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("pre_flush_pc", imemAddr, 64'h20);

        applyStimulus(0, 1, 1, 1, 64'h100);
        checkOutput("flush_pc",    imemAddr,   64'h100);
        checkOutput("flush_valid", ifIdValid,  1'b0);
        checkOutput("flush_instr", ifIdInstr,  NOP);
        checkOutput("flush_ifpc",  ifIdPc,     64'h0);
        checkOutput("flush_cnt",   flushCount, 32'd1);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("after_flush_ifpc",  ifIdPc,    64'h100);
        checkOutput("after_flush_instr", ifIdInstr, 32'd65);
        checkOutput("after_flush_pc",    imemAddr,  64'h104);

        applyStimulus(0, 0, 0, 1, 64'h200);
        checkOutput("flush_stall_pc",    imemAddr,   64'h200);
        checkOutput("flush_stall_valid", ifIdValid,  1'b0);
        checkOutput("flush_stall_scnt",  stallCount, 32'd3);
        checkOutput("flush_stall_fcnt",  flushCount, 32'd2);

        applyStimulus(0, 1, 1, 1, 64'h102);
        checkOutput("mis_pc",   imemAddr,   64'h100);
        checkOutput("mis_flag", misaligned, 1'b1);
        checkOutput("mis_fcnt", flushCount, 32'd3);
        repeat (10) applyStimulus(0, 1, 1, 0, 0);
        checkOutput("mis_sticky", misaligned, 1'b1);
        checkOutput("mis_run_pc", imemAddr,   64'h128);
        applyStimulus(1, 1, 1, 0, 0);
        checkResetState("rst2");

        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("mix_pc",    imemAddr,  64'h4);
        checkOutput("mix_valid", ifIdValid, 1'b0);
        checkOutput("mix_instr", ifIdInstr, NOP);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 1, 0, 0);
            checkOutput("dup_pc",    imemAddr,  64'h4);
            checkOutput("dup_ifpc",  ifIdPc,    64'h4);
            checkOutput("dup_instr", ifIdInstr, 32'd2);
            checkOutput("dup_valid", ifIdValid, 1'b1);
        end
        checkOutput("dup_scnt", stallCount, 32'd0);

        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 64'h40);
        checkOutput("first_flush_pc",    imemAddr,  64'h40);
        checkOutput("first_flush_valid", ifIdValid, 1'b0);
        checkOutput("first_flush_instr", ifIdInstr, NOP);
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("first_flush_ifpc",  ifIdPc,    64'h40);
        checkOutput("first_flush_inst2", ifIdInstr, 32'd17);

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("mid_stall_cnt", stallCount, 32'd2);
        applyStimulus(1, 0, 0, 0, 0);
        checkResetState("rst_mid_stall");

        // Second instance: reset just below the top of the address space.
        reset2 = 1'b1;
        @(posedge clk); #1;
        checkOutput("top_rst_pc", imemAddr2, TOP_PC);
        reset2 = 1'b0;
        @(posedge clk); #1;
        checkOutput("wrap_pc",    imemAddr2,  64'h0);
        checkOutput("wrap_ifpc",  ifIdPc2,    TOP_PC);
        checkOutput("wrap_instr", ifIdInstr2, 32'd0);
        @(posedge clk); #1;
        checkOutput("wrap_pc2", imemAddr2, 64'h4);

        pcWrite2   = 1'b0;
        ifIdWrite2 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            checkOutput("sat_scnt", stallCount2, (i < 3) ? 2'(i) : 2'd3);
        end
        flush2        = 1'b1;
        branchTarget2 = 64'h80;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            checkOutput("sat_fcnt", flushCount2, (i < 3) ? 2'(i) : 2'd3);
        end
        checkOutput("sat_scnt_hold", stallCount2, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
